cnn_cell_scheduler: RTL
=======================

// Module: cnn_cell_scheduler
// PURPOSE
// - Sequences Euler-style state updates for an array of CNN cells over one shared
//   output-nonlinearity unit (y = (|x+1| - |x-1|) >>> 1, WIDTH-bit signed, combinational).
// - Holds per-cell state, fetches each cell's dX from a derivative supplier by handshake,
//   drives the shared unit with (dX, state), writes back the new state, emits y per cell.
// - Runs num_iter full sweeps over all cells; sits between state init/load and the template engine.
// PARAMETERS
// - WIDTH   9   signed state/dX/y width, two's complement
// - NCELLS  16  number of cells, indices 0..NCELLS-1
// - IDX_W   4   cell index width, >= clog2(NCELLS)
// - ITER_W  8   iteration counter width
// PORTS
// - clk         in   1       rising-edge clock
// - rst_n       in   1       asynchronous active-low reset
// - start       in   1       begin run; sampled in IDLE only
// - num_iter    in   ITER_W  sweeps per run; sampled with start
// - load_valid  in   1       write initial state; honoured in IDLE only
// - load_idx    in   IDX_W   cell written by load
// - load_x      in   WIDTH   initial state value
// - dx_req      out  1       scheduler wants dX for dx_idx
// - dx_idx      out  IDX_W   cell whose dX is requested
// - dx_valid    in   1       dx_data valid; accepted only while dx_req=1
// - dx_data     in   WIDTH   signed dX
// - eq_dx       out  WIDTH   to shared unit dX input
// - eq_init_x   out  WIDTH   to shared unit Initial_X input (current cell state)
// - eq_out      in   WIDTH   shared unit result y, combinational from eq_dx/eq_init_x
// - y_valid     out  1       one-cycle strobe, y_data/y_idx valid
// - y_idx       out  IDX_W   cell of y_data
// - y_data      out  WIDTH   nonlinearity output of updated state
// - busy        out  1       high from start accept until DONE exits
// - done        out  1       one-cycle pulse at end of run
// - iter_cnt    out  ITER_W  completed sweeps in current/last run
// BEHAVIOUR
// - Reset: FSM=IDLE; all cell states=0; dx_req, y_valid, busy, done=0; dx_idx, y_idx, y_data,
//   eq_dx, eq_init_x, iter_cnt=0. Reset mid-run aborts immediately, no done pulse.
// - FSM: IDLE -> (start) REQ; REQ -> (dx_valid) APPLY; APPLY -> REQ (next cell) or
//   APPLY -> DONE (last cell of last sweep); DONE -> IDLE. start with num_iter=0: IDLE -> DONE.
// - IDLE: load_valid writes state[load_idx]<=load_x; load_idx>=NCELLS ignored. start clears
//   iter_cnt, cell idx=0, sets busy next cycle. Simultaneous start+load: load written first-cycle, then run.
// - REQ: dx_req=1, dx_idx=cell idx, both stable until dx_valid sampled high; dX captured to register.
// - APPLY (exactly 1 cycle): eq_dx=captured dX, eq_init_x=state[idx];
//   state[idx] <= dX+state (WIDTH-bit); y_valid=1, y_idx=idx, y_data=eq_out registered next
//   cycle-aligned with strobe (y_* registered from APPLY, visible first cycle after APPLY).
// - Cell wrap: idx NCELLS-1 -> 0 and iter_cnt+1; when iter_cnt+1==num_iter -> DONE.
// - DONE: done=1 for one cycle, busy drops with it; iter_cnt holds final value until next start.
// - Min throughput 2 cycles/cell; run of N sweeps with zero-stall supplier = 2*N*NCELLS+1 cycles
//   start-accept to done.
// - start/load while busy ignored; dx_valid while dx_req=0 ignored; num_iter changes mid-run ignored.
// CONFIGURATION
// - CNN_SAT_ADD_EN defined: state write-back saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
// - Undefined: state write-back wraps modulo 2^WIDTH (matches shared unit arithmetic).
// - eq_dx/eq_init_x/y_data unaffected; only stored state differs on overflow.
// TESTING
// - All states 0, num_iter=3, supplier dX=+1 zero-stall -> every state=3, y_data=1 each strobe,
//   48 y_valid strobes, done at cycle 97 after start accept, iter_cnt=3.
// - load cell 5 = -4, dX=+1, num_iter=1 -> y_idx=5 gives y_data=-1 (state -3); others y_data=1.
// - Supplier holds dx_valid low 5 cycles on cell 2 -> dx_req/dx_idx=2 stable 6 cycles, no y strobe.
// - start with num_iter=0 -> done pulse 1 cycle later, dx_req never high, states unchanged.
// - Cell 0 = 255, dX=+1, num_iter=1 -> state -256 without CNN_SAT_ADD_EN, 255 with it.
// - rst_n low during sweep 2 -> busy/dx_req/y_valid 0 asynchronously, states 0, no done.

Source files
------------

// File: rtl/cnn_cell_scheduler.sv
// -----------------------------------------------------------------------------
// cnn_cell_scheduler
//
// Sequences Euler-style state updates for NCELLS CNN cells through one shared,
// combinational output-nonlinearity unit. For each cell the scheduler requests
// dX from a supplier (dx_req/dx_valid handshake). It then presents
// (dX, state) to the shared unit for one APPLY cycle and writes back
// state + dX. The unit's y result is emitted registered on y_valid/y_idx/y_data.
// A run performs num_iter full sweeps over all cells.
//
// Configuration macro:
//   CNN_SAT_ADD_EN  - defined: stored state saturates on overflow;
//                     undefined: stored state wraps modulo 2^WIDTH.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, num_iter             begin a run of num_iter sweeps (IDLE only)
//   load_valid/idx/x            initial state write (IDLE only)
//   dx_req, dx_idx              dX request for a cell (held until dx_valid)
//   dx_valid, dx_data           dX response from supplier
//   eq_dx, eq_init_x, eq_out    shared nonlinearity unit interface
//   y_valid, y_idx, y_data      per-cell output strobe
//   busy, done, iter_cnt        run status
// -----------------------------------------------------------------------------
module cnn_cell_scheduler #(
    parameter int WIDTH  = 9,
    parameter int NCELLS = 16,
    parameter int IDX_W  = 4,
    parameter int ITER_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ITER_W-1:0] num_iter,
    input  logic              load_valid,
    input  logic [IDX_W-1:0]  load_idx,
    input  logic [WIDTH-1:0]  load_x,
    output logic              dx_req,
    output logic [IDX_W-1:0]  dx_idx,
    input  logic              dx_valid,
    input  logic [WIDTH-1:0]  dx_data,
    output logic [WIDTH-1:0]  eq_dx,
    output logic [WIDTH-1:0]  eq_init_x,
    input  logic [WIDTH-1:0]  eq_out,
    output logic              y_valid,
    output logic [IDX_W-1:0]  y_idx,
    output logic [WIDTH-1:0]  y_data,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] iter_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_APPLY = 2'd2,
        S_DONE  = 2'd3
    } fsm_t;

    fsm_t              fsm_q, fsm_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [ITER_W-1:0] num_iter_q, num_iter_d;
    logic [WIDTH-1:0]  cell_x_q [NCELLS];
    logic [WIDTH-1:0]  cell_x_d [NCELLS];
    logic              dx_req_q, dx_req_d;
    logic [IDX_W-1:0]  dx_idx_q, dx_idx_d;
    logic [WIDTH-1:0]  eq_dx_q, eq_dx_d;
    logic [WIDTH-1:0]  eq_init_x_q, eq_init_x_d;
    logic              y_valid_q, y_valid_d;
    logic [IDX_W-1:0]  y_idx_q, y_idx_d;
    logic [WIDTH-1:0]  y_data_q, y_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              last_cell_s;
    logic [ITER_W-1:0] iter_inc_s;
    logic [IDX_W-1:0]  idx_inc_s;

    // State write-back adder; only the stored state is affected by saturation,
    // the shared unit always sees the raw operands.
    function automatic logic [WIDTH-1:0] next_state(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
`ifdef CNN_SAT_ADD_EN
        logic [WIDTH:0] sum;
        sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (sum[WIDTH] != sum[WIDTH-1]) begin
            next_state = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            next_state = sum[WIDTH-1:0];
        end
`else
        next_state = a + b;
`endif
    endfunction

    assign last_cell_s = (idx_q == IDX_W'(NCELLS - 1));
    assign iter_inc_s  = iter_q + ITER_W'(1);
    assign idx_inc_s   = idx_q + IDX_W'(1);

    // Next-state and output computation for the scheduler FSM.
    always_comb begin
        fsm_d       = fsm_q;
        idx_d       = idx_q;
        iter_d      = iter_q;
        num_iter_d  = num_iter_q;
        cell_x_d    = cell_x_q;
        dx_req_d    = 1'b0;
        dx_idx_d    = dx_idx_q;
        eq_dx_d     = eq_dx_q;
        eq_init_x_d = eq_init_x_q;
        y_valid_d   = 1'b0;
        y_idx_d     = y_idx_q;
        y_data_d    = y_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                // A load in the same cycle as start still lands before the run.
                if (load_valid && (int'(load_idx) < NCELLS)) begin
                    cell_x_d[load_idx] = load_x;
                end else begin
                    cell_x_d = cell_x_q;
                end
                if (start) begin
                    iter_d     = '0;
                    idx_d      = '0;
                    num_iter_d = num_iter;
                    busy_d     = 1'b1;
                    dx_idx_d   = '0;
                    if (num_iter == '0) begin
                        fsm_d = S_DONE;
                    end else begin
                        fsm_d    = S_REQ;
                        dx_req_d = 1'b1;
                    end
                end else begin
                    fsm_d = S_IDLE;
                end
            end
            S_REQ: begin
                // eq_dx/eq_init_x double as the captured operands for APPLY.
                if (dx_valid) begin
                    eq_dx_d     = dx_data;
                    eq_init_x_d = cell_x_q[idx_q];
                    fsm_d       = S_APPLY;
                end else begin
                    dx_req_d = 1'b1;
                end
            end
            S_APPLY: begin
                cell_x_d[idx_q] = next_state(eq_dx_q, eq_init_x_q);
                y_valid_d       = 1'b1;
                y_idx_d         = idx_q;
                y_data_d        = eq_out;
                if (last_cell_s) begin
                    iter_d = iter_inc_s;
                    if (iter_inc_s == num_iter_q) begin
                        fsm_d = S_DONE;
                    end else begin
                        fsm_d    = S_REQ;
                        idx_d    = '0;
                        dx_req_d = 1'b1;
                        dx_idx_d = '0;
                    end
                end else begin
                    fsm_d    = S_REQ;
                    idx_d    = idx_inc_s;
                    dx_req_d = 1'b1;
                    dx_idx_d = idx_inc_s;
                end
            end
            S_DONE: begin
                done_d = 1'b1;
                busy_d = 1'b0;
                fsm_d  = S_IDLE;
            end
            default: begin
                fsm_d  = S_IDLE;
                busy_d = 1'b0;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= S_IDLE;
            idx_q       <= '0;
            iter_q      <= '0;
            num_iter_q  <= '0;
            for (int i = 0; i < NCELLS; i++) begin
                cell_x_q[i] <= '0;
            end
            dx_req_q    <= 1'b0;
            dx_idx_q    <= '0;
            eq_dx_q     <= '0;
            eq_init_x_q <= '0;
            y_valid_q   <= 1'b0;
            y_idx_q     <= '0;
            y_data_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            idx_q       <= idx_d;
            iter_q      <= iter_d;
            num_iter_q  <= num_iter_d;
            cell_x_q    <= cell_x_d;
            dx_req_q    <= dx_req_d;
            dx_idx_q    <= dx_idx_d;
            eq_dx_q     <= eq_dx_d;
            eq_init_x_q <= eq_init_x_d;
            y_valid_q   <= y_valid_d;
            y_idx_q     <= y_idx_d;
            y_data_q    <= y_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign dx_req    = dx_req_q;
    assign dx_idx    = dx_idx_q;
    assign eq_dx     = eq_dx_q;
    assign eq_init_x = eq_init_x_q;
    assign y_valid   = y_valid_q;
    assign y_idx     = y_idx_q;
    assign y_data    = y_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign iter_cnt  = iter_q;

endmodule
